// File: rtl/inventory_pkg.sv
// Shared types and defaults for the vending-machine stock store (restock and dispense sides).
// Latency: n/a (declarations only).
// Backpressure: n/a.
package inventory_pkg;

    localparam int DEF_NUM_PRODUCTS = 4;
    localparam int DEF_PW           = 2;
    localparam int DEF_SW           = 4;
    localparam int DEF_MAX_STOCK    = 10;
    localparam int DEF_INIT_STOCK   = 10;

    typedef logic [DEF_SW-1:0] stock_t;
    typedef logic [DEF_PW-1:0] product_t;

    typedef enum logic [2:0] {
        INIT  = 3'd0,
        IDLE  = 3'd1,
        READ  = 3'd2,
        WRITE = 3'd3,
        DONE  = 3'd4,
        FILL  = 3'd5
    } state_t;

endpackage

// File: rtl/stock_ram.sv
// Per-product stock RAM: one write port, two registered read ports, read-before-write.
// Latency: 1 cycle on both read ports; writes land at the clock edge.
// Backpressure: none, accepts a write and two reads every cycle.
module stock_ram #(
    parameter int DEPTH = 4,
    parameter int AW    = 2,
    parameter int DW    = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr_a,
    output logic [DW-1:0] rdata_a,
    input  logic [AW-1:0] raddr_b,
    output logic [DW-1:0] rdata_b
);

    logic [DW-1:0] mem [DEPTH];

    // Storage array: no reset, contents are rebuilt by the owner's init sweep.
    always_ff @(posedge clk) begin
        if (we && (int'(waddr) < DEPTH)) begin
            mem[waddr] <= wdata;
        end
    end

    // Registered reads sample the array before any same-edge write; unmapped slots read 0.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rdata_a <= '0;
            rdata_b <= '0;
        end else begin
            rdata_a <= (int'(raddr_a) < DEPTH) ? mem[raddr_a] : '0;
            rdata_b <= (int'(raddr_b) < DEPTH) ? mem[raddr_b] : '0;
        end
    end

endmodule

// File: rtl/inventory_restock.sv
// Restock engine: adds operator quantities to per-slot stock, saturating at capacity; bulk refill.
// Latency: handshake at T, done pulse at T+3, ready again at T+4; sweeps take NUM_PRODUCTS cycles.
// Backpressure: restock_ready is high only in IDLE; one request in flight at a time.
module inventory_restock
    import inventory_pkg::*;
#(
    parameter int NUM_PRODUCTS = DEF_NUM_PRODUCTS,
    parameter int PW           = DEF_PW,
    parameter int SW           = DEF_SW,
    parameter int MAX_STOCK    = DEF_MAX_STOCK,
    parameter int INIT_STOCK   = DEF_INIT_STOCK
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    restock_valid,
    output logic                    restock_ready,
    input  logic [PW-1:0]           restock_product,
    input  logic [SW-1:0]           restock_qty,
    input  logic                    refill_all,
    output logic                    done,
    output logic [SW-1:0]           accepted,
    output logic [SW-1:0]           overflow,
    output logic                    err,
    input  logic [PW-1:0]           rd_product,
    output logic [SW-1:0]           rd_stock,
    output logic [NUM_PRODUCTS-1:0] full_mask
);

    localparam logic [SW-1:0] MAX_V     = SW'(MAX_STOCK);
    localparam logic [SW-1:0] INIT_V    = SW'(INIT_STOCK);
    localparam logic [PW-1:0] LAST_ADDR = PW'(NUM_PRODUCTS - 1);

    state_t        state;
    state_t        state_nxt;
    logic [PW-1:0] sweep_addr;
    logic          sweep_last;
    logic [PW-1:0] cap_product;
    logic [SW-1:0] cap_qty;
    logic          prod_ok;

    logic [SW-1:0] cur_stock;
    logic [SW:0]   sum;
    logic [SW-1:0] new_stock;
    logic [SW-1:0] add_acc;
    logic [SW-1:0] add_ovf;

    logic          ram_we;
    logic [PW-1:0] ram_waddr;
    logic [SW-1:0] ram_wdata;

    assign sweep_last    = (sweep_addr == LAST_ADDR);
    assign prod_ok       = (int'(cap_product) < NUM_PRODUCTS);
    assign restock_ready = (state == IDLE);
    assign done          = (state == DONE);

    // Port a follows the captured slot so the value is ready in WRITE; port b serves the display.
    stock_ram #(
        .DEPTH (NUM_PRODUCTS),
        .AW    (PW),
        .DW    (SW)
    ) u_ram (
        .clk     (clk),
        .rst     (rst),
        .we      (ram_we),
        .waddr   (ram_waddr),
        .wdata   (ram_wdata),
        .raddr_a (cap_product),
        .rdata_a (cur_stock),
        .raddr_b (rd_product),
        .rdata_b (rd_stock)
    );

    // Saturating add done one bit wider so the carry is never lost before clamping.
    always_comb begin
        sum       = {1'b0, cur_stock} + {1'b0, cap_qty};
        new_stock = (sum > {1'b0, MAX_V}) ? MAX_V : sum[SW-1:0];
        add_acc   = new_stock - cur_stock;
        add_ovf   = SW'(sum - {1'b0, new_stock});
    end

    // Next-state decode; a pending restock outranks refill_all.
    always_comb begin
        state_nxt = state;
        case (state)
            INIT:    if (sweep_last) state_nxt = IDLE;
            IDLE: begin
                if (restock_valid)   state_nxt = READ;
                else if (refill_all) state_nxt = FILL;
            end
            READ:    state_nxt = WRITE;
            WRITE:   state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            FILL:    if (sweep_last) state_nxt = DONE;
            default: state_nxt = INIT;
        endcase
    end

    // Single RAM write port shared by the sweeps and the restock update.
    always_comb begin
        ram_we    = 1'b0;
        ram_waddr = sweep_addr;
        ram_wdata = INIT_V;
        case (state)
            INIT: ram_we = 1'b1;
            FILL: begin
                ram_we    = 1'b1;
                ram_wdata = MAX_V;
            end
            WRITE: begin
                ram_we    = prod_ok;
                ram_waddr = cap_product;
                ram_wdata = new_stock;
            end
            default: ram_we = 1'b0;
        endcase
    end

    // State register; reset always restarts the init sweep.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= INIT;
        else      state <= state_nxt;
    end

    // Sweep address walks all slots and rewinds so the next sweep starts at slot 0.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sweep_addr <= '0;
        end else if ((state == INIT) || (state == FILL)) begin
            sweep_addr <= sweep_last ? '0 : sweep_addr + 1'b1;
        end
    end

    // Request capture on the IDLE handshake.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cap_product <= '0;
            cap_qty     <= '0;
        end else if ((state == IDLE) && restock_valid) begin
            cap_product <= restock_product;
            cap_qty     <= restock_qty;
        end
    end

    // Per-request results, held until the next restock completes.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            accepted <= '0;
            overflow <= '0;
            err      <= 1'b0;
        end else if (state == WRITE) begin
            if (prod_ok) begin
                accepted <= add_acc;
                overflow <= add_ovf;
                err      <= 1'b0;
            end else begin
                accepted <= '0;
                overflow <= cap_qty;
                err      <= 1'b1;
            end
        end
    end

    // Full flags track every RAM write so they never need a separate scan.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            full_mask <= '0;
        end else begin
            for (int i = 0; i < NUM_PRODUCTS; i++) begin
                if (ram_we && (ram_waddr == PW'(i))) begin
                    full_mask[i] <= (ram_wdata == MAX_V);
                end
            end
        end
    end

endmodule
